// File: rtl/t_block_seq.sv
// Sequencer that streams DH joint parameters from a small register file into a
// fixed-latency t_block and tags each issued joint so the results can be tracked.
module t_block_seq #(
  parameter int NJ  = 6,
  parameter int LAT = 26,
  parameter int W   = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_joint,
  input  logic [1:0]   cfg_field,
  input  logic [W-1:0] cfg_data,
  input  logic [3:0]   num_joints,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] tb_alpha,
  output logic [W-1:0] tb_theta,
  output logic [W-1:0] tb_a,
  output logic [W-1:0] tb_d,
  output logic         tb_en,
  output logic         res_valid,
  output logic [2:0]   res_joint
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [3:0] NJ4   = 4'(NJ);

  logic [1:0]   state;
  logic [2:0]   idx;
  logic [3:0]   n;
  logic [W-1:0] alpha_rf [NJ];
  logic [W-1:0] theta_rf [NJ];
  logic [W-1:0] a_rf     [NJ];
  logic [W-1:0] d_rf     [NJ];
  logic [3:0]   tag_sr   [LAT];
  logic [3:0]   tag_push;
  logic         start_ok;
  logic         last_issue;
  logic         cfg_ok;

  assign start_ok   = (num_joints != 4'd0) && (num_joints <= NJ4);
  assign last_issue = (state == ISSUE) && ({1'b0, idx} == n - 4'd1);
  assign cfg_ok     = cfg_we && (state == IDLE) && ({1'b0, cfg_joint} < NJ4);

  assign busy      = (state != IDLE);
  assign tb_en     = (state != IDLE);
  assign err       = (state == IDLE) && start && !start_ok;
  assign res_valid = tag_sr[LAT-1][3];
  assign res_joint = tag_sr[LAT-1][2:0];
  assign done      = (state == DRAIN) && res_valid && ({1'b0, res_joint} == n - 4'd1);

  // A write in the same IDLE cycle as start commits on the start edge, so the
  // first ISSUE cycle already reads the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NJ; i++) begin
        alpha_rf[i] <= '0;
        theta_rf[i] <= '0;
        a_rf[i]     <= '0;
        d_rf[i]     <= '0;
      end
    end else if (cfg_ok) begin
      case (cfg_field)
        2'd0:    alpha_rf[cfg_joint] <= cfg_data;
        2'd1:    theta_rf[cfg_joint] <= cfg_data;
        2'd2:    a_rf[cfg_joint]     <= cfg_data;
        default: d_rf[cfg_joint]     <= cfg_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      n     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && start_ok) begin
            n     <= num_joints;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          idx <= idx + 3'd1;
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tb_alpha = '0;
    tb_theta = '0;
    tb_a     = '0;
    tb_d     = '0;
    tag_push = 4'd0;
    if (state == ISSUE) begin
      tb_alpha = alpha_rf[idx];
      tb_theta = theta_rf[idx];
      tb_a     = a_rf[idx];
      tb_d     = d_rf[idx];
      tag_push = {1'b1, idx};
    end
  end

  // The tag pipe mirrors the t_block delay so each result carries its joint index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_sr[i] <= 4'd0;
    end else begin
      tag_sr[0] <= tag_push;
      for (int i = 1; i < LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

endmodule

// File: tb/tb_t_block_seq.sv
// Self-checking bench for t_block_seq: directed runs with a scoreboard of
// expected result cycles and joint indices.
module tb_t_block_seq;

  localparam int NJ  = 6;
  localparam int LAT = 26;
  localparam int W   = 27;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_joint = '0;
  logic [1:0]   cfg_field = '0;
  logic [W-1:0] cfg_data = '0;
  logic [3:0]   num_joints = '0;
  logic         start = 1'b0;
  logic         busy, done, err, tb_en, res_valid;
  logic [W-1:0] tb_alpha, tb_theta, tb_a, tb_d;
  logic [2:0]   res_joint;

  typedef struct {
    int cyc;
    int joint;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   thetaM [NJ];
  int   aM [NJ];

  t_block_seq #(.NJ(NJ), .LAT(LAT), .W(W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_joint(cfg_joint),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .num_joints(num_joints),
    .start(start), .busy(busy), .done(done), .err(err),
    .tb_alpha(tb_alpha), .tb_theta(tb_theta), .tb_a(tb_a), .tb_d(tb_d),
    .tb_en(tb_en), .res_valid(res_valid), .res_joint(res_joint)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input int j, input int f, input int d);
    tick();
    cfg_we = 1'b1; cfg_joint = 3'(j); cfg_field = 2'(f); cfg_data = W'(d);
    if (j < NJ && f == 1) thetaM[j] = d;
    if (j < NJ && f == 2) aM[j] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Cycle 0 is the start cycle; every check samples 3 time units after a rising edge.
  task automatic applyStimulus(input int n, input bit busyPoke, input bit drainWrite, input bit sameWrite);
    exp_t e;
    int   expDone;
    tick();
    start = 1'b1; num_joints = 4'(n);
    if (sameWrite) begin
      cfg_we = 1'b1; cfg_joint = 3'd0; cfg_field = 2'd1; cfg_data = W'(100);
      thetaM[0] = 100;
    end
    #2;
    checkOutput("err_on_accept", err, 0);
    checkOutput("busy_c0", busy, 0);
    for (int j = 0; j < n; j++) sb.push_back('{1 + j + LAT, j});
    expDone = n + LAT;
    for (int c = 1; c <= n + LAT + 3; c++) begin
      tick();
      start = 1'b0; cfg_we = 1'b0;
      if (busyPoke && c == 3) begin start = 1'b1; num_joints = 4'(n); end
      if (drainWrite && c == n + 2) begin
        cfg_we = 1'b1; cfg_joint = 3'd0; cfg_field = 2'd1; cfg_data = W'(12345);
      end
      #2;
      if (busyPoke && c == 3) checkOutput("no_err_busy", err, 0);
      checkOutput("busy", busy, 64'(c <= expDone));
      checkOutput("tb_en", tb_en, 64'(c <= expDone));
      if (c <= n) begin
        checkOutput("tb_theta", tb_theta, 64'(thetaM[c-1]));
        checkOutput("tb_a", tb_a, 64'(aM[c-1]));
      end else begin
        checkOutput("tb_theta_idle", tb_theta, 0);
      end
      if (res_valid) begin
        if (sb.size() == 0) checkOutput("unexpected_valid", res_valid, 0);
        else begin
          e = sb.pop_front();
          checkOutput("res_cycle", 64'(c), 64'(e.cyc));
          checkOutput("res_joint", res_joint, 64'(e.joint));
        end
      end
      checkOutput("done", done, 64'(c == expDone));
    end
    start = 1'b0; cfg_we = 1'b0;
    checkOutput("sb_empty", 64'(sb.size()), 0);
  endtask

  initial begin
    for (int j = 0; j < NJ; j++) begin thetaM[j] = 0; aM[j] = 0; end
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tb_en", tb_en, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_res_joint", res_joint, 0);
    #20 rst = 1'b0;

    for (int j = 0; j < NJ; j++) begin
      writeReg(j, 1, 256 * j);
      writeReg(j, 2, j + 1);
    end
    writeReg(6, 1, 999);

    $display("[TB] six-joint run with busy start and dropped drain write");
    applyStimulus(6, 1'b1, 1'b1, 1'b0);
    applyStimulus(6, 1'b0, 1'b0, 1'b0);

    $display("[TB] rejected starts");
    for (int k = 0; k < 2; k++) begin
      tick();
      start = 1'b1; num_joints = (k == 0) ? 4'd0 : 4'd7;
      #2;
      checkOutput("err_pulse", err, 1);
      checkOutput("err_busy", busy, 0);
      checkOutput("err_tb_en", tb_en, 0);
      tick();
      start = 1'b0;
      #2;
      checkOutput("err_one_cycle", err, 0);
      checkOutput("err_stays_idle", busy, 0);
    end

    $display("[TB] single joint and same-cycle write");
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset mid-run");
    tick();
    start = 1'b1; num_joints = 4'd6;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_tb_en", tb_en, 0);
    checkOutput("mrst_res_valid", res_valid, 0);
    checkOutput("mrst_done", done, 0);
    checkOutput("mrst_theta", tb_theta, 0);
    #1 rst = 1'b0;
    for (int j = 0; j < NJ; j++) begin thetaM[j] = 0; aM[j] = 0; end
    for (int c = 11; c <= LAT + 10; c++) begin
      tick();
      #2;
      checkOutput("mrst_no_valid", res_valid, 0);
      checkOutput("mrst_no_done", done, 0);
    end
    for (int j = 0; j < NJ; j++) writeReg(j, 1, 7 * j + 3);
    applyStimulus(6, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t_block_seq.md
T_BLOCK_SEQ -- requirements
Module: t_block_seq

Interface
REQ-001 Parameter NJ, default 6: maximum number of joints held in the DH parameter register file (1..8).
REQ-002 Parameter LAT, default 26: cycles from parameters presented to t_block until the matching t_matrix is valid.
REQ-003 Parameter W, default 27: fixed-point word width of all DH fields.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cfg_we  in  1  write strobe into the register file.
REQ-007 cfg_joint  in  3  joint index to write.
REQ-008 cfg_field  in  2  field select: 0=alpha, 1=theta, 2=a, 3=d.
REQ-009 cfg_data  in  W  value to write.
REQ-010 num_joints  in  4  joints in the chain; sampled on start.
REQ-011 start  in  1  single-cycle request to run the chain.
REQ-012 busy  out  1  high from the accepted start until done.
REQ-013 done  out  1  one-cycle pulse coincident with the last res_valid.
REQ-014 err  out  1  one-cycle pulse when a start is rejected.
REQ-015 tb_alpha, tb_theta, tb_a, tb_d  out  W each  DH inputs to t_block.
REQ-016 tb_en  out  1  t_block enable.
REQ-017 res_valid  out  1  the t_matrix currently leaving t_block is valid.
REQ-018 res_joint  out  3  joint index of that t_matrix.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE and DRAIN.
REQ-020 In IDLE, start with 1<=num_joints<=NJ SHALL latch n=num_joints, clear idx to 0 and enter ISSUE on the next edge.
REQ-021 In IDLE, start with num_joints=0 or num_joints>NJ SHALL pulse err for one cycle and remain in IDLE.
REQ-022 start while busy SHALL be ignored; no err is raised.
REQ-023 In ISSUE, each cycle SHALL drive tb_* from register file entry idx, push a tag {1,idx} into an LAT-deep shift register, and increment idx.
REQ-024 When idx=n-1 in ISSUE, the FSM SHALL enter DRAIN on the next edge; issue is back-to-back with no bubbles.
REQ-025 In IDLE and DRAIN, tb_* SHALL be driven to 0 and the pushed tag SHALL be {0,0}.
REQ-026 tb_en SHALL be 1 in ISSUE and DRAIN and 0 in IDLE; the t_block delay lines cannot stall, so there is no backpressure.
REQ-027 res_valid and res_joint SHALL be the tag output of the shift register: parameters issued in cycle k give res_valid in cycle k+LAT.
REQ-028 In DRAIN, when res_valid=1 and res_joint=n-1, done SHALL pulse that cycle and the FSM SHALL return to IDLE on the next edge; busy falls on that edge.
REQ-029 cfg_we SHALL write the register file only in IDLE; writes while busy SHALL be dropped.
REQ-030 cfg_we with cfg_joint>=NJ SHALL be ignored.
REQ-031 If cfg_we and start occur in the same IDLE cycle, the write SHALL commit and the run SHALL use the new value.
REQ-032 The register file SHALL retain its contents across runs and is not cleared by done.

Reset
REQ-033 rst SHALL immediately force IDLE, idx=0 and n=0, clear every tag stage, and drive busy, done, err, tb_en, res_valid and res_joint to 0 and tb_* to 0.
REQ-034 The register file SHALL reset to all-zero.
REQ-035 rst asserted mid-ISSUE or mid-DRAIN SHALL abort the run with no further res_valid and no done.

Verification
REQ-036 Write 6 joints (theta=256*j), num_joints=6, start at cycle 0 -> tb_en from cycle 1; res_valid cycles 27..32 with res_joint 0..5; done at 32; busy low at 33.
REQ-037 start with num_joints=0, then with num_joints=7 (NJ=6) -> err pulses each time; busy stays 0; tb_en stays 0.
REQ-038 num_joints=1 -> exactly one res_valid, res_joint=0, with done in the same cycle, LAT+1 cycles after start.
REQ-039 cfg_we during DRAIN, then a second run -> the second run's tb_theta shows the pre-run value; start during busy gives neither err nor restart.
REQ-040 rst at cycle 10 of a 6-joint run -> all outputs 0 asynchronously; no res_valid or done follows; a fresh start then runs normally.
REQ-041 Same-cycle cfg_we (joint 0, theta=100) and start -> tb_theta=100 on the first issue cycle.
